steuerung_erweitert: RTL and testbench
======================================

// Module: steuerung_erweitert
// PURPOSE
//  Parametrised multi-cycle control FSM for the Hans core. Drives fetch, decode, ALU, jump/load/store
//  writeback and PC update. Adds the following over the base control unit:
//  - wait-state timeouts with trap
//  - maskable interrupt at instruction boundary
//  - halt state
//  - cycle and instruction performance counters
// PARAMETERS
//  TIMEOUT  16  max cycles in any wait state before trap; 0 = timeouts disabled
//  CNT_W    32  width of TaktZaehler / BefehlZaehler
// PORTS
//  Clock                    in   1      system clock, rising edge
//  ResetN                   in   1      asynchronous, active-low reset
//  BefehlGeladen            in   1      instruction fetch complete
//  LoadBefehl/StoreBefehl   in   1      decoded load / store
//  JALBefehl                in   1      decoded JAL
//  UnbedingterSprungBefehl  in   1      decoded unconditional jump
//  BedingterSprungBefehl    in   1      decoded branch
//  Bedingung                in   1      branch condition true
//  HaltBefehl               in   1      decoded halt
//  ALUFertig                in   1      ALU result valid
//  DatenGeladen             in   1      load complete
//  DatenGespeichert         in   1      store complete
//  Interrupt                in   1      level interrupt request
//  InterruptEnable          in   1      interrupt mask (1 = enabled)
//  LoadBefehlSignal         out  1      request instruction fetch
//  DekodierSignal           out  1      latch decode
//  ALUStartSignal           out  1      start ALU (1-cycle pulse)
//  RegisterSchreibSignal    out  1      register-file write enable
//  LoadDatenSignal          out  1      memory read request
//  StoreDatenSignal         out  1      memory write request
//  PCSignal                 out  1      PC update enable (1 pulse per retired instruction)
//  PCSprungSignal           out  1      PC source = jump target
//  TrapSignal               out  1      trap pulse (1 cycle)
//  TrapUrsache              out  2      last trap cause: 0 fetch TO, 1 ALU TO, 2 mem TO, 3 IRQ
//  Angehalten               out  1      core halted
//  TaktZaehler              out  CNT_W  cycles since reset
//  BefehlZaehler            out  CNT_W  retired instructions
// BEHAVIOUR
//  States: FETCH, DECODE, ALU_START, ALU_WAIT, WB_JUMP, WB_STORE, WB_LOAD, WB_DEFAULT, TRAP, HALT.
//  ResetN=0 (async, any state):
//   - state=FETCH; counters, TrapUrsache and wait counter = 0.
//   - Outputs are a combinational decode of state, so LoadBefehlSignal=1 and all other outputs = 0.
//  Transitions:
//   - FETCH: -> DECODE on BefehlGeladen.
//   - DECODE: -> HALT if HaltBefehl, else -> ALU_START.
//   - ALU_START / ALU_WAIT:
//     - If ALUFertig, select writeback with priority jump(either) > store > load > default.
//     - Otherwise ALU_START -> ALU_WAIT, and ALU_WAIT stays in ALU_WAIT.
//   - WB_JUMP, WB_DEFAULT: 1 cycle.
//   - WB_STORE / WB_LOAD: stay until DatenGespeichert / DatenGeladen.
//   - HALT: absorbing until reset.
//  Instruction boundary = any WB exit:
//   - If Interrupt & InterruptEnable in that cycle, go to TRAP with cause 3.
//   - Otherwise go to FETCH.
//  TRAP: 1 cycle, then FETCH; TrapUrsache is registered on entry and held until the next trap.
//  Timeout (TIMEOUT>0) applies in FETCH, ALU_WAIT, WB_LOAD, WB_STORE:
//   - Wait counter clears on state entry.
//   - After TIMEOUT consecutive cycles in the state without completion -> TRAP.
//   - Cause: FETCH=0, ALU_WAIT=1, LOAD/STORE=2.
//   - Completion in the same cycle as expiry wins (no trap).
//  Output decode:
//   - LoadBefehlSignal = FETCH; DekodierSignal = DECODE; ALUStartSignal = ALU_START.
//   - RegisterSchreibSignal = (ALU_START & JALBefehl) | WB_DEFAULT.
//   - StoreDatenSignal = WB_STORE; LoadDatenSignal = WB_LOAD.
//   - PCSignal = WB_JUMP | WB_DEFAULT | (WB_STORE & DatenGespeichert) | (WB_LOAD & DatenGeladen).
//   - PCSprungSignal = WB_JUMP & (UnbedingterSprungBefehl | (BedingterSprungBefehl & Bedingung)).
//   - TrapSignal = TRAP; Angehalten = HALT.
//  Counters:
//   - TaktZaehler increments every cycle except in HALT.
//   - BefehlZaehler increments on each PCSignal.
//   - Both wrap modulo 2^CNT_W.
// TESTING
//  1. ALU op, BefehlGeladen@c1, ALUFertig@ALU_START -> DECODE c2, ALU_START c3, WB_DEFAULT c4
//     (RegWrite=1, PCSignal=1), FETCH c5; BefehlZaehler=1.
//  2. Branch, Bedingung=0 -> PCSignal=1, PCSprungSignal=0. Same with Bedingung=1 -> PCSprungSignal=1.
//  3. Load, DatenGeladen after 5 cycles -> LoadDatenSignal high 6 cycles, PCSignal only in the last.
//  4. TIMEOUT=4, store never acked -> TrapSignal 1 cycle after 4 cycles, TrapUrsache=2, then FETCH.
//  5. Interrupt=1 with InterruptEnable=0 -> no trap. With InterruptEnable=1 at WB_DEFAULT ->
//     TRAP (cause 3), PCSignal still pulsed.
//  6. HaltBefehl -> Angehalten=1, TaktZaehler frozen. ResetN low mid-ALU_WAIT -> FETCH and
//     counters 0 without waiting for a clock edge.

Source files
------------

// File: rtl/steuerung_erweitert.sv
// Multi-cycle control FSM for the Hans core. It sequences fetch, decode, ALU,
// the writeback variants and the PC update. On top of that it provides
// wait-state timeouts that trap, a maskable interrupt taken at instruction
// boundaries, a halt state, and cycle/instruction performance counters.
module steuerung_erweitert #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             BefehlGeladen,
    input  logic             LoadBefehl,
    input  logic             StoreBefehl,
    input  logic             JALBefehl,
    input  logic             UnbedingterSprungBefehl,
    input  logic             BedingterSprungBefehl,
    input  logic             Bedingung,
    input  logic             HaltBefehl,
    input  logic             ALUFertig,
    input  logic             DatenGeladen,
    input  logic             DatenGespeichert,
    input  logic             Interrupt,
    input  logic             InterruptEnable,
    output logic             LoadBefehlSignal,
    output logic             DekodierSignal,
    output logic             ALUStartSignal,
    output logic             RegisterSchreibSignal,
    output logic             LoadDatenSignal,
    output logic             StoreDatenSignal,
    output logic             PCSignal,
    output logic             PCSprungSignal,
    output logic             TrapSignal,
    output logic [1:0]       TrapUrsache,
    output logic             Angehalten,
    output logic [CNT_W-1:0] TaktZaehler,
    output logic [CNT_W-1:0] BefehlZaehler
);

    typedef enum logic [3:0] {
        FETCH, DECODE, ALU_START, ALU_WAIT, WB_JUMP,
        WB_STORE, WB_LOAD, WB_DEFAULT, TRAP, HALT
    } zustandT;

    // Wide enough to hold TIMEOUT-1, the last cycle before a wait state expires.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    zustandT           zustand;
    zustandT           zustandNext;
    zustandT           wbZiel;
    zustandT           grenzeZiel;
    logic [1:0]        ursacheNext;
    logic [1:0]        grenzeUrsache;
    logic [WAIT_W-1:0] waitCnt;
    logic              timeoutHit;
    logic              irqAnfrage;

    // Expiry happens in the TIMEOUT-th consecutive cycle of a wait state;
    // a completion in that same cycle is checked first and therefore wins.
    assign timeoutHit = (TIMEOUT > 0) && (waitCnt == WAIT_W'(TIMEOUT - 1));
    assign irqAnfrage = Interrupt & InterruptEnable;

    // Writeback selection once the ALU is done: jump > store > load > default.
    always_comb begin
        wbZiel = WB_DEFAULT;
        if (UnbedingterSprungBefehl | BedingterSprungBefehl) begin
            wbZiel = WB_JUMP;
        end else if (StoreBefehl) begin
            wbZiel = WB_STORE;
        end else if (LoadBefehl) begin
            wbZiel = WB_LOAD;
        end
    end

    // Instruction boundary: a pending enabled interrupt diverts to TRAP.
    always_comb begin
        grenzeZiel    = FETCH;
        grenzeUrsache = TrapUrsache;
        if (irqAnfrage) begin
            grenzeZiel    = TRAP;
            grenzeUrsache = 2'd3;
        end
    end

    // Next-state logic; the trap cause is computed only for transitions into TRAP.
    always_comb begin
        zustandNext = zustand;
        ursacheNext = TrapUrsache;
        unique case (zustand)
            FETCH: begin
                if (BefehlGeladen) begin
                    zustandNext = DECODE;
                end else if (timeoutHit) begin
                    zustandNext = TRAP;
                    ursacheNext = 2'd0;
                end
            end
            DECODE:    zustandNext = HaltBefehl ? HALT : ALU_START;
            ALU_START: zustandNext = ALUFertig ? wbZiel : ALU_WAIT;
            ALU_WAIT: begin
                if (ALUFertig) begin
                    zustandNext = wbZiel;
                end else if (timeoutHit) begin
                    zustandNext = TRAP;
                    ursacheNext = 2'd1;
                end
            end
            WB_JUMP, WB_DEFAULT: begin
                zustandNext = grenzeZiel;
                ursacheNext = grenzeUrsache;
            end
            WB_STORE, WB_LOAD: begin
                if ((zustand == WB_STORE) ? DatenGespeichert : DatenGeladen) begin
                    zustandNext = grenzeZiel;
                    ursacheNext = grenzeUrsache;
                end else if (timeoutHit) begin
                    zustandNext = TRAP;
                    ursacheNext = 2'd2;
                end
            end
            TRAP:    zustandNext = FETCH;
            HALT:    zustandNext = HALT;
            default: zustandNext = FETCH;
        endcase
    end

    // State register and latched trap cause.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            zustand     <= FETCH;
            TrapUrsache <= 2'd0;
        end else begin
            zustand     <= zustandNext;
            TrapUrsache <= ursacheNext;
        end
    end

    // Wait counter restarts on every state change, counts while the state holds.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            waitCnt <= '0;
        end else if (zustandNext != zustand) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    // Performance counters: cycles outside HALT and retired instructions.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            TaktZaehler   <= '0;
            BefehlZaehler <= '0;
        end else begin
            if (zustand != HALT) begin
                TaktZaehler <= TaktZaehler + 1'b1;
            end
            if (PCSignal) begin
                BefehlZaehler <= BefehlZaehler + 1'b1;
            end
        end
    end

    assign LoadBefehlSignal      = (zustand == FETCH);
    assign DekodierSignal        = (zustand == DECODE);
    assign ALUStartSignal        = (zustand == ALU_START);
    assign RegisterSchreibSignal = ((zustand == ALU_START) & JALBefehl) | (zustand == WB_DEFAULT);
    assign StoreDatenSignal      = (zustand == WB_STORE);
    assign LoadDatenSignal       = (zustand == WB_LOAD);
    assign PCSignal              = (zustand == WB_JUMP) | (zustand == WB_DEFAULT)
                                 | ((zustand == WB_STORE) & DatenGespeichert)
                                 | ((zustand == WB_LOAD) & DatenGeladen);
    assign PCSprungSignal        = (zustand == WB_JUMP)
                                 & (UnbedingterSprungBefehl | (BedingterSprungBefehl & Bedingung));
    assign TrapSignal            = (zustand == TRAP);
    assign Angehalten            = (zustand == HALT);

endmodule

// File: tb/tb_steuerung_erweitert.sv
// Bench for steuerung_erweitert: instruction plans are turned into a cycle
// timeline by arithmetic, expected retire/trap events go into a scoreboard
// queue, and a monitor pops and compares on every PCSignal or TrapSignal.
module tb_steuerung_erweitert;

    localparam int TO = 4;

    logic        Clock;
    logic        ResetN;
    logic        BefehlGeladen, LoadBefehl, StoreBefehl, JALBefehl;
    logic        UnbedingterSprungBefehl, BedingterSprungBefehl, Bedingung, HaltBefehl;
    logic        ALUFertig, DatenGeladen, DatenGespeichert, Interrupt, InterruptEnable;
    logic        LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal;
    logic        LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal, TrapSignal;
    logic [1:0]  TrapUrsache;
    logic        Angehalten;
    logic [31:0] TaktZaehler, BefehlZaehler;

    steuerung_erweitert #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .Clock(Clock), .ResetN(ResetN),
        .BefehlGeladen(BefehlGeladen), .LoadBefehl(LoadBefehl), .StoreBefehl(StoreBefehl),
        .JALBefehl(JALBefehl), .UnbedingterSprungBefehl(UnbedingterSprungBefehl),
        .BedingterSprungBefehl(BedingterSprungBefehl), .Bedingung(Bedingung),
        .HaltBefehl(HaltBefehl), .ALUFertig(ALUFertig), .DatenGeladen(DatenGeladen),
        .DatenGespeichert(DatenGespeichert), .Interrupt(Interrupt),
        .InterruptEnable(InterruptEnable), .LoadBefehlSignal(LoadBefehlSignal),
        .DekodierSignal(DekodierSignal), .ALUStartSignal(ALUStartSignal),
        .RegisterSchreibSignal(RegisterSchreibSignal), .LoadDatenSignal(LoadDatenSignal),
        .StoreDatenSignal(StoreDatenSignal), .PCSignal(PCSignal),
        .PCSprungSignal(PCSprungSignal), .TrapSignal(TrapSignal), .TrapUrsache(TrapUrsache),
        .Angehalten(Angehalten), .TaktZaehler(TaktZaehler), .BefehlZaehler(BefehlZaehler)
    );

    typedef struct {
        bit          isTrap;
        bit [1:0]    cause;
        bit          sprung;
        bit          regWr;
        bit          memSig;
        int unsigned cyc;
        int unsigned bcnt;
    } evT;

    evT          sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int unsigned bcnt  = 0;
    bit [1:0]    lastCause = 2'd0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushTrap(input bit [1:0] cause, input int at);
        evT e;
        e = '{isTrap: 1'b1, cause: cause, sprung: 1'b0, regWr: 1'b0, memSig: 1'b0,
              cyc: at, bcnt: bcnt};
        sb.push_back(e);
        lastCause = cause;
    endtask

    task automatic pushRetire(input int op, input bit cond, input int at);
        evT e;
        e = '{isTrap: 1'b0, cause: lastCause, sprung: (op == 2) || (op == 1 && cond),
              regWr: (op == 0), memSig: (op >= 3), cyc: at, bcnt: bcnt};
        sb.push_back(e);
        bcnt++;
    endtask

    // op: 0 ALU, 1 branch, 2 unconditional jump, 3 load, 4 store.
    // fD/aD/mD: cycles of waiting before fetch / ALU / memory completion.
    task automatic runInstr(input int op, input bit cond, input int fD, input int aD,
                            input int mD, input bit irq, input bit ie);
        int s, a, w, ex, nxt;
        int geladenAt, fertigAt, memAt;
        s = cyc; geladenAt = -1; fertigAt = -1; memAt = -1; w = -1; ex = -1; nxt = s + 1;
        if (fD >= TO) begin
            pushTrap(2'd0, s + TO);
            nxt = s + TO + 1;
        end else begin
            geladenAt = s + fD;
            a = s + fD + 2;
            if (aD == 0) begin
                fertigAt = a; w = a + 1;
            end else if (aD > TO) begin
                pushTrap(2'd1, a + 1 + TO);
                nxt = a + 2 + TO;
            end else begin
                fertigAt = a + aD; w = a + 1 + aD;
            end
            if (w >= 0) begin
                if (op >= 3 && mD >= TO) begin
                    pushTrap(2'd2, w + TO);
                    nxt = w + TO + 1;
                end else begin
                    if (op >= 3) memAt = w + mD;
                    ex = (op >= 3) ? w + mD : w;
                    pushRetire(op, cond, ex);
                    if (irq && ie) begin
                        pushTrap(2'd3, ex + 1);
                        nxt = ex + 2;
                    end else begin
                        nxt = ex + 1;
                    end
                end
            end
        end
        LoadBefehl = (op == 3); StoreBefehl = (op == 4);
        UnbedingterSprungBefehl = (op == 2); BedingterSprungBefehl = (op == 1);
        Bedingung = cond; HaltBefehl = 1'b0; JALBefehl = 1'b0;
        Interrupt = irq; InterruptEnable = ie;
        for (int c = s; c < nxt; c++) begin
            BefehlGeladen    = (c == geladenAt);
            ALUFertig        = (c == fertigAt);
            DatenGeladen     = (op == 3) && (c == memAt);
            DatenGespeichert = (op == 4) && (c == memAt);
            @(negedge Clock);
        end
        BefehlGeladen = 1'b0; ALUFertig = 1'b0; DatenGeladen = 1'b0; DatenGespeichert = 1'b0;
        cyc = nxt;
    endtask

    // Monitor: every retire or trap pulse must match the next scoreboard entry.
    initial begin
        evT e;
        forever begin
            @(negedge Clock);
            #2;
            if (ResetN && (PCSignal || TrapSignal)) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_event: PC=%0b Trap=%0b with empty queue", PCSignal, TrapSignal);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_trap", TrapSignal, e.isTrap);
                    chk("event_pc_pulse", PCSignal, !e.isTrap);
                    chk("event_cycle", TaktZaehler, e.cyc);
                    chk("event_trap_cause", TrapUrsache, e.cause);
                    if (!e.isTrap) begin
                        chk("retire_pc_jump", PCSprungSignal, e.sprung);
                        chk("retire_reg_write", RegisterSchreibSignal, e.regWr);
                        chk("retire_mem_req", LoadDatenSignal | StoreDatenSignal, e.memSig);
                        chk("retire_count", BefehlZaehler, e.bcnt);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, fD, aD, mD, s;
        bit cond, irq, ie;
        ResetN = 1'b0;
        BefehlGeladen = 0; LoadBefehl = 0; StoreBefehl = 0; JALBefehl = 0;
        UnbedingterSprungBefehl = 0; BedingterSprungBefehl = 0; Bedingung = 0; HaltBefehl = 0;
        ALUFertig = 0; DatenGeladen = 0; DatenGespeichert = 0; Interrupt = 0; InterruptEnable = 0;
        repeat (2) @(negedge Clock);
        #2;
        chk("reset_fetch_req", LoadBefehlSignal, 1'b1);
        chk("reset_other_outs", {DekodierSignal, ALUStartSignal, RegisterSchreibSignal,
            LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal, TrapSignal, Angehalten}, 9'd0);
        chk("reset_takt", TaktZaehler, 0);
        chk("reset_befehl", BefehlZaehler, 0);
        chk("reset_cause", TrapUrsache, 0);
        @(negedge Clock);
        ResetN = 1'b1; cyc = 0; bcnt = 0; lastCause = 2'd0;

        // Directed: ALU op, branches, slow load, unacked store, interrupts.
        runInstr(0, 0, 0, 0, 0, 0, 0);
        runInstr(1, 0, 0, 1, 0, 0, 0);
        runInstr(1, 1, 1, 0, 0, 0, 0);
        runInstr(3, 0, 0, 0, 5, 0, 0);
        runInstr(4, 0, 0, 0, 99, 0, 0);
        runInstr(0, 0, 0, 0, 0, 1, 0);
        runInstr(0, 0, 0, 0, 0, 1, 1);
        runInstr(2, 0, 3, TO, TO - 1, 0, 0);
        runInstr(0, 0, TO, 0, 0, 0, 0);
        runInstr(0, 0, 0, TO + 1, 0, 0, 0);
        runInstr(4, 0, 0, 2, TO - 1, 1, 1);

        // Randomised instruction mix.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4); cond = 1'($urandom_range(0, 1));
            fD = $urandom_range(0, 5); aD = $urandom_range(0, 6); mD = $urandom_range(0, 6);
            irq = 1'($urandom_range(0, 1)); ie = 1'($urandom_range(0, 1));
            runInstr(op, cond, fD, aD, mD, irq, ie);
        end

        // Halt: cycle counter freezes, core stays halted.
        s = cyc;
        HaltBefehl = 1'b1; BefehlGeladen = 1'b1; Interrupt = 0; InterruptEnable = 0;
        @(negedge Clock);
        BefehlGeladen = 1'b0;
        @(negedge Clock);
        #2;
        chk("halt_flag", Angehalten, 1'b1);
        chk("halt_takt", TaktZaehler, s + 2);
        chk("halt_no_fetch", LoadBefehlSignal, 1'b0);
        repeat (3) @(negedge Clock);
        #2;
        chk("halt_takt_frozen", TaktZaehler, s + 2);
        chk("halt_still", Angehalten, 1'b1);

        // Asynchronous reset out of HALT, mid clock phase.
        ResetN = 1'b0;
        #1;
        chk("areset_halt_fetch", LoadBefehlSignal, 1'b1);
        chk("areset_halt_flag", Angehalten, 1'b0);
        chk("areset_halt_takt", TaktZaehler, 0);
        @(negedge Clock);
        ResetN = 1'b1; HaltBefehl = 1'b0; cyc = 0; bcnt = 0; lastCause = 2'd0;
        runInstr(0, 0, 0, 0, 0, 0, 0);
        runInstr(4, 0, 0, 0, 99, 0, 0);

        // Asynchronous reset while waiting on the ALU.
        s = cyc;
        LoadBefehl = 0; StoreBefehl = 0; BefehlGeladen = 1'b1;
        @(negedge Clock);
        BefehlGeladen = 1'b0;
        repeat (3) @(negedge Clock);
        #2;
        chk("alu_wait_idle", {LoadBefehlSignal, ALUStartSignal, DekodierSignal}, 3'd0);
        chk("alu_wait_takt", TaktZaehler, s + 4);
        ResetN = 1'b0;
        #1;
        chk("areset_wait_fetch", LoadBefehlSignal, 1'b1);
        chk("areset_wait_takt", TaktZaehler, 0);
        chk("areset_wait_befehl", BefehlZaehler, 0);
        chk("areset_wait_cause", TrapUrsache, 0);
        @(negedge Clock);
        ResetN = 1'b1; cyc = 0; bcnt = 0; lastCause = 2'd0;
        runInstr(0, 0, 1, 2, 0, 0, 0);

        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
